// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle between the execute/memory producers and the register-file write port.
// The arbiter uses the slave modport; the producer side (core or bench) uses the master modport.
interface wb_port_arbiter_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            alu_valid;
    logic [REGW-1:0] alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            jal_valid;
    logic [REGW-1:0] jal_rd;
    logic [XLEN-1:0] jal_data;
    logic            jal_ready;

    logic            ld_valid;
    logic [REGW-1:0] ld_rd;
    logic [XLEN-1:0] ld_data;

    logic            ldq_afull;
    logic            ldq_ovf;

    logic            rf_we;
    logic [REGW-1:0] rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [1:0]      wb_sel;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  jal_valid, jal_rd, jal_data,
        input  ld_valid, ld_rd, ld_data,
        output alu_ready, jal_ready,
        output ldq_afull, ldq_ovf,
        output rf_we, rf_rd, rf_wdata, wb_sel
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output jal_valid, jal_rd, jal_data,
        output ld_valid, ld_rd, ld_data,
        input  alu_ready, jal_ready,
        input  ldq_afull, ldq_ovf,
        input  rf_we, rf_rd, rf_wdata, wb_sel
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: ALU, JAL link and a load-return FIFO share one write per cycle.
// Optional macro WB_ARB_STATS_EN adds saturating stall / force-entry statistics outputs.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int REGW         = 5,
    parameter int LDQ_DEPTH    = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wb_port_arbiter_if.slave       bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]            stat_ld_stall,
    output logic [15:0]            stat_force
`endif
);
    localparam int PTRW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int CNTW = PTRW + 1;
    localparam int STW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(LDQ_DEPTH);
    localparam logic [CNTW-1:0] AFULL_C = CNTW'(LDQ_DEPTH - 1);
    localparam logic [STW-1:0]  LIMIT_C = STW'(STARVE_LIMIT);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_LD  = 2'b01;
    localparam logic [1:0] SEL_JAL = 2'b10;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [STW-1:0]  r_starve;
    logic [STW-1:0]  w_starve_nxt;

    logic [REGW-1:0] r_ldq_rd   [LDQ_DEPTH];
    logic [XLEN-1:0] r_ldq_data [LDQ_DEPTH];
    logic [PTRW-1:0] r_wptr;
    logic [PTRW-1:0] r_rptr;
    logic [CNTW-1:0] r_count;
    logic [CNTW-1:0] w_count_nxt;
    logic            r_ldq_afull;
    logic            r_ldq_ovf;

    logic            w_head_vld;
    logic            w_full;
    logic            w_push_ok;
    logic            w_ovf_evt;

    logic            w_gnt_fifo;
    logic            w_gnt_jal;
    logic            w_gnt_alu;
    logic            w_any_gnt;

    logic [REGW-1:0] w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic [1:0]      w_sel_src;

    logic            r_rf_we;
    logic [REGW-1:0] r_rf_rd;
    logic [XLEN-1:0] r_rf_wdata;
    logic [1:0]      r_wb_sel;

    assign w_head_vld = (r_count != {CNTW{1'b0}});
    assign w_full     = (r_count == DEPTH_C);

    // Grant selection and next arbitration state; grants are only ever made from registered FIFO state.
    always_comb begin
        w_gnt_fifo   = 1'b0;
        w_gnt_jal    = 1'b0;
        w_gnt_alu    = 1'b0;
        w_state_nxt  = ST_NORMAL;
        w_starve_nxt = {STW{1'b0}};
        if (rst_n) begin
            case (r_state)
                ST_FORCE: begin
                    if (bus.jal_valid) begin
                        w_gnt_jal = 1'b1;
                    end else if (bus.alu_valid) begin
                        w_gnt_alu = 1'b1;
                    end else if (w_head_vld) begin
                        w_gnt_fifo = 1'b1;
                    end else begin
                        w_gnt_fifo = 1'b0;
                    end
                    w_state_nxt  = ST_NORMAL;
                    w_starve_nxt = {STW{1'b0}};
                end
                ST_NORMAL: begin
                    if (w_head_vld) begin
                        w_gnt_fifo = 1'b1;
                    end else if (bus.jal_valid) begin
                        w_gnt_jal = 1'b1;
                    end else if (bus.alu_valid) begin
                        w_gnt_alu = 1'b1;
                    end else begin
                        w_gnt_fifo = 1'b0;
                    end
                    // Only a denial caused by the FIFO counts toward starvation.
                    if (w_gnt_jal || w_gnt_alu || !(bus.alu_valid || bus.jal_valid)) begin
                        w_starve_nxt = {STW{1'b0}};
                    end else if (w_gnt_fifo) begin
                        w_starve_nxt = r_starve + STW'(1);
                    end else begin
                        w_starve_nxt = r_starve;
                    end
                    if (w_starve_nxt >= LIMIT_C) begin
                        w_state_nxt = ST_FORCE;
                    end else begin
                        w_state_nxt = ST_NORMAL;
                    end
                end
                default: begin
                    w_state_nxt  = ST_NORMAL;
                    w_starve_nxt = {STW{1'b0}};
                end
            endcase
        end else begin
            w_state_nxt  = ST_NORMAL;
            w_starve_nxt = {STW{1'b0}};
        end
    end

    assign w_any_gnt     = w_gnt_fifo | w_gnt_jal | w_gnt_alu;
    assign bus.alu_ready = w_gnt_alu;
    assign bus.jal_ready = w_gnt_jal;

    // Mux the granted source onto the write-port inputs; without a grant the old values are kept.
    always_comb begin
        w_sel_rd   = r_rf_rd;
        w_sel_data = r_rf_wdata;
        w_sel_src  = r_wb_sel;
        if (w_gnt_fifo) begin
            w_sel_rd   = r_ldq_rd[r_rptr];
            w_sel_data = r_ldq_data[r_rptr];
            w_sel_src  = SEL_LD;
        end else if (w_gnt_jal) begin
            w_sel_rd   = bus.jal_rd;
            w_sel_data = bus.jal_data;
            w_sel_src  = SEL_JAL;
        end else if (w_gnt_alu) begin
            w_sel_rd   = bus.alu_rd;
            w_sel_data = bus.alu_data;
            w_sel_src  = SEL_ALU;
        end else begin
            w_sel_rd   = r_rf_rd;
            w_sel_data = r_rf_wdata;
            w_sel_src  = r_wb_sel;
        end
    end

    // Load FIFO occupancy update; a pop frees the slot so push-at-full with pop is legal.
    always_comb begin
        w_push_ok   = rst_n & bus.ld_valid & (~w_full | w_gnt_fifo);
        w_ovf_evt   = rst_n & bus.ld_valid & w_full & ~w_gnt_fifo;
        w_count_nxt = r_count;
        case ({w_push_ok, w_gnt_fifo})
            2'b10:   w_count_nxt = r_count + CNTW'(1);
            2'b01:   w_count_nxt = r_count - CNTW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Arbitration state register and starvation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_NORMAL;
            r_starve <= {STW{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr      <= {PTRW{1'b0}};
            r_rptr      <= {PTRW{1'b0}};
            r_count     <= {CNTW{1'b0}};
            r_ldq_afull <= 1'b0;
            r_ldq_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTRW'(1);
            end
            if (w_gnt_fifo) begin
                r_rptr <= r_rptr + PTRW'(1);
            end
            r_count     <= w_count_nxt;
            r_ldq_afull <= (w_count_nxt >= AFULL_C);
            r_ldq_ovf   <= r_ldq_ovf | w_ovf_evt;
        end
    end

    // FIFO storage; contents of empty slots are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_ldq_rd[r_wptr]   <= bus.ld_rd;
            r_ldq_data[r_wptr] <= bus.ld_data;
        end
    end

    // Registered write port; x0 grants still update the select but never raise the write enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= {REGW{1'b0}};
            r_rf_wdata <= {XLEN{1'b0}};
            r_wb_sel   <= SEL_ALU;
        end else begin
            r_rf_we    <= w_any_gnt & (w_sel_rd != {REGW{1'b0}});
            r_rf_rd    <= w_sel_rd;
            r_rf_wdata <= w_sel_data;
            r_wb_sel   <= w_sel_src;
        end
    end

    assign bus.rf_we     = r_rf_we;
    assign bus.rf_rd     = r_rf_rd;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.wb_sel    = r_wb_sel;
    assign bus.ldq_afull = r_ldq_afull;
    assign bus.ldq_ovf   = r_ldq_ovf;

`ifdef WB_ARB_STATS_EN
    logic [15:0] r_stat_ld_stall;
    logic [15:0] r_stat_force;
    logic        w_core_denied;
    logic        w_force_entry;

    assign w_core_denied = (bus.alu_valid & ~w_gnt_alu) | (bus.jal_valid & ~w_gnt_jal);
    assign w_force_entry = (r_state == ST_NORMAL) & (w_state_nxt == ST_FORCE);

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_ld_stall <= 16'h0000;
            r_stat_force    <= 16'h0000;
        end else begin
            if (w_core_denied && (r_stat_ld_stall != 16'hFFFF)) begin
                r_stat_ld_stall <= r_stat_ld_stall + 16'h0001;
            end
            if (w_force_entry && (r_stat_force != 16'hFFFF)) begin
                r_stat_force <= r_stat_force + 16'h0001;
            end
        end
    end

    assign stat_ld_stall = r_stat_ld_stall;
    assign stat_force    = r_stat_force;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed test-plan steps followed by a randomized phase,
// all compared against a queue-based transaction model of the writeback rules.
module tb_wb_port_arbiter;
    localparam int XLEN         = 32;
    localparam int REGW         = 5;
    localparam int LDQ_DEPTH    = 2;
    localparam int STARVE_LIMIT = 3;

    logic clk;
    logic rst_n;

    wb_port_arbiter_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

`ifdef WB_ARB_STATS_EN
    logic [15:0] stat_ld_stall;
    logic [15:0] stat_force;
`endif

    wb_port_arbiter #(
        .XLEN(XLEN), .REGW(REGW), .LDQ_DEPTH(LDQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_ld_stall(stat_ld_stall),
        .stat_force(stat_force)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] data;
    } ent_t;

    int vectors;
    int miscompares;

    // Reference model state
    ent_t            mq[$];
    bit              m_force;
    int              m_starve;
    logic            m_ovf;
    logic            m_rf_we;
    logic [REGW-1:0] m_rf_rd;
    logic [XLEN-1:0] m_rf_wdata;
    logic [1:0]      m_wb_sel;
    int              m_stall;
    int              m_nforce;
    int              last_g;   // 0 none, 1 load, 2 jal, 3 alu

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_force    = 1'b0;
        m_starve   = 0;
        m_ovf      = 1'b0;
        m_rf_we    = 1'b0;
        m_rf_rd    = '0;
        m_rf_wdata = '0;
        m_wb_sel   = 2'b00;
        m_stall    = 0;
        m_nforce   = 0;
    endtask

    // One clock: check ready before the edge, advance the model, check registered outputs after it.
    task automatic tick();
        int   g;
        bit   av, jv, lv, rs;
        ent_t a, j, l, w;
        #1;
        rs = rst_n; av = bus.alu_valid; jv = bus.jal_valid; lv = bus.ld_valid;
        a.rd = bus.alu_rd; a.data = bus.alu_data;
        j.rd = bus.jal_rd; j.data = bus.jal_data;
        l.rd = bus.ld_rd;  l.data = bus.ld_data;
        g = 0;
        if (rs) begin
            if (m_force) g = jv ? 2 : (av ? 3 : (mq.size() > 0 ? 1 : 0));
            else         g = (mq.size() > 0) ? 1 : (jv ? 2 : (av ? 3 : 0));
        end
        chk("alu_ready", bus.alu_ready, (g == 3));
        chk("jal_ready", bus.jal_ready, (g == 2));
        @(posedge clk);
        last_g = g;
        if (!rs) begin
            model_reset();
        end else begin
            if (g != 0) begin
                w = (g == 1) ? mq[0] : ((g == 2) ? j : a);
                m_rf_we    = (w.rd != 0);
                m_rf_rd    = w.rd;
                m_rf_wdata = w.data;
                m_wb_sel   = (g == 1) ? 2'b01 : ((g == 2) ? 2'b10 : 2'b00);
            end else begin
                m_rf_we = 1'b0;
            end
            if (g == 1) void'(mq.pop_front());
            if (lv) begin
                if (mq.size() < LDQ_DEPTH) mq.push_back(l);
                else m_ovf = 1'b1;
            end
            if ((av && g != 3) || (jv && g != 2)) begin
                if (m_stall < 16'hFFFF) m_stall++;
            end
            if (m_force) begin
                m_force  = 1'b0;
                m_starve = 0;
            end else if (g == 2 || g == 3 || !(av || jv)) begin
                m_starve = 0;
            end else begin
                m_starve++;
                if (m_starve == STARVE_LIMIT) begin
                    m_force  = 1'b1;
                    m_starve = 0;
                    if (m_nforce < 16'hFFFF) m_nforce++;
                end
            end
        end
        #1;
        chk("rf_we", bus.rf_we, m_rf_we);
        chk("rf_rd", bus.rf_rd, m_rf_rd);
        chk("rf_wdata", bus.rf_wdata, m_rf_wdata);
        chk("wb_sel", bus.wb_sel, m_wb_sel);
        chk("ldq_afull", bus.ldq_afull, (mq.size() >= LDQ_DEPTH - 1));
        chk("ldq_ovf", bus.ldq_ovf, m_ovf);
`ifdef WB_ARB_STATS_EN
        chk("stat_ld_stall", stat_ld_stall, m_stall);
        chk("stat_force", stat_force, m_nforce);
`endif
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.jal_valid = 1'b0; bus.ld_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int denied;
        bit acc;
        vectors = 0; miscompares = 0; last_g = 0;
        model_reset();
        idle();
        bus.alu_rd = 5'd3; bus.alu_data = 32'h0; bus.jal_rd = 5'd0; bus.jal_data = 32'h0;
        bus.ld_rd = 5'd0; bus.ld_data = 32'h0;

        // Reset with a concurrent request: reset wins
        rst_n = 1'b0;
        bus.alu_valid = 1'b1;
        tick();
        tick();
        chk("reset_rf_we", bus.rf_we, 1'b0);
        chk("reset_wdata", bus.rf_wdata, 32'h0);
        rst_n = 1'b1;
        idle();
        tick();

        // Single ALU write
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000_1234;
        tick();
        chk("alu_we", bus.rf_we, 1'b1);
        chk("alu_rd", bus.rf_rd, 5'd5);
        chk("alu_data", bus.rf_wdata, 32'h0000_1234);
        chk("alu_sel", bus.wb_sel, 2'b00);
        idle();

        // Load latency of two cycles
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h0000_DEAD;
        tick();
        chk("ld_we_t1", bus.rf_we, 1'b0);
        chk("ld_afull", bus.ldq_afull, 1'b1);
        idle();
        tick();
        chk("ld_we_t2", bus.rf_we, 1'b1);
        chk("ld_rd", bus.rf_rd, 5'd7);
        chk("ld_sel", bus.wb_sel, 2'b01);

        // JAL beats ALU in the same cycle
        bus.jal_valid = 1'b1; bus.jal_rd = 5'd1; bus.jal_data = 32'h0000_0104;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h0000_0022;
        tick();
        chk("jal_first_sel", bus.wb_sel, 2'b10);
        chk("jal_first_data", bus.rf_wdata, 32'h0000_0104);
        bus.jal_valid = 1'b0;
        tick();
        chk("alu_second_rd", bus.rf_rd, 5'd2);
        idle();

        // Starvation: continuous loads, ALU held until forced through
        do_reset();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = $urandom;
        tick();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hA1A1_0001;
        denied = 0; acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            bus.ld_rd = 5'(10 + i); bus.ld_data = $urandom;
            tick();
            if (last_g == 3) acc = 1'b1;
            else denied++;
        end
        chk("starve_denials_1", denied, 3);
        chk("ovf_before", bus.ldq_ovf, 1'b0);
`ifdef WB_ARB_STATS_EN
        chk("stat_force_1", stat_force, 16'd1);
`endif
        // FIFO now full: push with pop keeps it full, no overflow
        bus.alu_valid = 1'b0; bus.ld_rd = 5'd20; bus.ld_data = $urandom;
        tick();
        chk("full_afull", bus.ldq_afull, 1'b1);
        chk("full_pushpop_ovf", bus.ldq_ovf, 1'b0);
        // Second forced cycle pushes at full with no pop
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'hA1A1_0002;
        denied = 0; acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            bus.ld_rd = 5'(21 + i); bus.ld_data = $urandom;
            tick();
            if (last_g == 3) acc = 1'b1;
            else denied++;
        end
        chk("starve_denials_2", denied, 3);
        chk("ovf_after", bus.ldq_ovf, 1'b1);
        idle();
        for (int i = 0; i < 4; i++) tick();

        // x0 destination: accepted but not written
        do_reset();
        chk("ovf_cleared", bus.ldq_ovf, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_FFFF;
        tick();
        chk("x0_ready", last_g, 3);
        chk("x0_we", bus.rf_we, 1'b0);
        chk("x0_sel", bus.wb_sel, 2'b00);
        idle();

        // Reset mid-burst with a non-empty FIFO
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_data = 32'h4444_0000;
        tick();
        bus.ld_rd = 5'd6; bus.ld_data = 32'h6666_0000;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_we", bus.rf_we, 1'b0);
        chk("midrst_afull", bus.ldq_afull, 1'b0);
        chk("midrst_ovf", bus.ldq_ovf, 1'b0);
        rst_n = 1'b1;
        idle();
        tick();
        chk("midrst_empty", bus.rf_we, 1'b0);

        // Randomized traffic respecting valid-hold-until-ready
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!bus.alu_valid || last_g == 3) begin
                bus.alu_valid = ($urandom_range(0, 99) < 40);
                bus.alu_rd    = 5'($urandom_range(0, 31));
                bus.alu_data  = $urandom;
            end
            if (!bus.jal_valid || last_g == 2) begin
                bus.jal_valid = ($urandom_range(0, 99) < 25);
                bus.jal_rd    = 5'($urandom_range(0, 31));
                bus.jal_data  = $urandom;
            end
            bus.ld_valid = ($urandom_range(0, 99) < 35);
            bus.ld_rd    = 5'($urandom_range(0, 31));
            bus.ld_data  = $urandom;
            tick();
            if (!rst_n) last_g = 0;
        end
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between three result producers: ALU, load return, and JAL/JALR link (PC+4).
- Buffers load returns in a small FIFO, since loads cannot be back-pressured, and arbitrates one write per cycle.
- Drives registered rf_we/rf_rd/rf_wdata plus a 2-bit wb_sel using result-select encoding: 00 ALU, 01 load, 10 PC+4.
- Sits between execute/memory stages and the register file.

Parameters:
XLEN, 32, data width
REGW, 5, register index width
LDQ_DEPTH, 2, load-return FIFO entries (power of two, >=2)
STARVE_LIMIT, 3, consecutive denied cycles before a core requester is forced through

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
alu_valid  in  1  ALU result wants writeback
alu_rd  in  REGW  ALU destination
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU result accepted this cycle (combinational)
jal_valid  in  1  link write request
jal_rd  in  REGW  link destination
jal_data  in  XLEN  PC+4
jal_ready  out  1  link accepted this cycle (combinational)
ld_valid  in  1  load data returning (no back-pressure)
ld_rd  in  REGW  load destination
ld_data  in  XLEN  load data
ldq_afull  out  1  load FIFO count >= LDQ_DEPTH-1; core must stop issuing loads
ldq_ovf  out  1  sticky: push while full
rf_we  out  1  register-file write enable
rf_rd  out  REGW  write index
rf_wdata  out  XLEN  write data
wb_sel  out  2  source of current write (00/01/10)

Behaviour:
- Reset (rst_n low at edge): rf_we=0, rf_rd=0, rf_wdata=0, wb_sel=00, FIFO emptied, ldq_afull=0, ldq_ovf=0, starve counter=0, state=NORMAL. Reset wins over any concurrent request.
- Load FIFO:
  - Push on every ld_valid.
  - Pop when its head is granted.
  - Push and pop in the same cycle are both allowed, including at full (count unchanged).
  - Push while full and no pop: entry dropped, ldq_ovf set until reset.
  - Pointers wrap modulo LDQ_DEPTH.
- Arbitration uses registered FIFO state; at most one grant per cycle.
- State NORMAL, priority: FIFO head > JAL > ALU.
- starve counter:
  - Increments each cycle a core requester (alu_valid or jal_valid) is denied because the FIFO was granted.
  - Clears on any core grant or when no core requester is valid.
- NORMAL -> FORCE when counter reaches STARVE_LIMIT.
- State FORCE, for exactly one cycle:
  - Priority is JAL > ALU > FIFO head.
  - Then return to NORMAL with counter=0.
  - If FORCE is entered but no core request remains valid, grant the FIFO normally and return to NORMAL.
- alu_ready/jal_ready are combinational from grant; a requester holds valid/rd/data stable until ready.
- Latency:
  - ALU/JAL accepted in cycle t -> rf_we=1 in cycle t+1.
  - Load returning in cycle t into an empty FIFO with no competition -> rf_we=1 in cycle t+2.
- Granted source drives registered outputs next cycle: rf_rd, rf_wdata, wb_sel (ALU 00, load 01, JAL 10).
- No grant -> rf_we=0; rf_rd/rf_wdata/wb_sel hold their previous values.
- rd==0 grants are accepted/popped normally but produce rf_we=0 (x0 never written); wb_sel still updates.
- Ordering: loads leave in return order; no reordering between FIFO entries.

Optional Feature:
Macro WB_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_ld_stall[15:0] and stat_force[15:0].
  - stat_ld_stall counts cycles with a core requester denied.
  - stat_force counts FORCE entries.
  - Both are saturating, cleared by reset.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then alu_valid=1, alu_rd=5, alu_data=0x1234 -> alu_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234, wb_sel=00.
- ld_valid=1 (rd=7, data=0xDEAD) with no other requests -> two cycles later rf_we=1, rf_rd=7, wb_sel=01; ldq_afull high while entry is queued (DEPTH=2).
- Same-cycle jal_valid (rd=1, data=0x104) and alu_valid (rd=2) with empty FIFO -> JAL written first (wb_sel=10), ALU the following cycle.
- Continuous ld_valid each cycle plus steady alu_valid -> ALU denied exactly 3 cycles, forced through on the 4th arbitration cycle; with WB_ARB_STATS_EN stat_force=1.
- Three back-to-back ld_valid with ALU held off and FIFO=2 -> entries pop in order; at full, push-with-pop keeps count at 2 and ldq_ovf stays 0; push at full with no pop (FORCE cycle) sets ldq_ovf=1.
- alu_rd=0, data=0xFFFF -> alu_ready=1, next cycle rf_we=0; rst_n low mid-burst with FIFO non-empty -> next cycle FIFO empty, rf_we=0, ldq_ovf=0.
